// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the execute stage.
//   alu_op_e     : 3-bit ALU operation codes
//   fwd_sel_e    : operand forwarding select codes (11 is reserved and
//                  behaves like FWD_REG)
//   result_src_e : write-back result select codes
//   XLEN_DEF / REG_ADDR_W_DEF : default datapath and register address widths
package pipeline_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU for the execute stage.
// Ports:
//   src_a, src_b : operands (XLEN bits)
//   op           : operation (alu_op_e)
//   result       : XLEN-bit result, wrap-around arithmetic
//   zero         : result == 0
module alu
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_XOR: result = src_a ^ src_b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            // Shift amount is always the low five bits of src_b.
            ALU_SLL: result = src_a << src_b[4:0];
            ALU_SRL: result = src_a >> src_b[4:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register (stall = hold, flush = bubble, carries valid).
// Ports:
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_*_EX                  : ID/EX register outputs for the instruction in EX
//   i_alu_result_MEM        : forwarding source from MEM
//   i_result_WB             : forwarding source from WB
//   i_stall, i_flush        : EX/MEM register control (flush wins)
//   o_pc_src_EX             : combinational fetch redirect
//   o_pc_target_EX          : combinational branch/jump target (pc + imm)
//   o_*_MEM                 : EX/MEM register outputs
module ex_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid_EX,
    input  logic [XLEN-1:0]       i_dataA_EX,
    input  logic [XLEN-1:0]       i_dataB_EX,
    input  logic [XLEN-1:0]       i_pc_EX,
    input  logic [XLEN-1:0]       i_pc_plus4_EX,
    input  logic [XLEN-1:0]       i_imm_ext_EX,
    input  logic [REG_ADDR_W-1:0] i_addr_des_EX,
    input  logic                  i_alu_src_EX,
    input  logic                  i_branch_EX,
    input  logic                  i_jump_EX,
    input  logic                  i_mem_write_EX,
    input  logic                  i_reg_write_EX,
    input  logic [2:0]            i_alu_control_EX,
    input  logic [1:0]            i_result_src_EX,
    input  logic [1:0]            i_forward_a_EX,
    input  logic [1:0]            i_forward_b_EX,
    input  logic [XLEN-1:0]       i_alu_result_MEM,
    input  logic [XLEN-1:0]       i_result_WB,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic                  o_pc_src_EX,
    output logic [XLEN-1:0]       o_pc_target_EX,
    output logic [XLEN-1:0]       o_alu_result_MEM,
    output logic [XLEN-1:0]       o_write_data_MEM,
    output logic [XLEN-1:0]       o_pc_plus4_MEM,
    output logic [REG_ADDR_W-1:0] o_addr_des_MEM,
    output logic                  o_reg_write_MEM,
    output logic                  o_mem_write_MEM,
    output logic [1:0]            o_result_src_MEM,
    output logic                  o_valid_MEM
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // Forwarding muxes; the reserved code 11 falls through to the register value.
    always_comb begin
        src_a = i_dataA_EX;
        case (i_forward_a_EX)
            FWD_WB:  src_a = i_result_WB;
            FWD_MEM: src_a = i_alu_result_MEM;
            default: src_a = i_dataA_EX;
        endcase
    end

    always_comb begin
        fwd_b = i_dataB_EX;
        case (i_forward_b_EX)
            FWD_WB:  fwd_b = i_result_WB;
            FWD_MEM: fwd_b = i_alu_result_MEM;
            default: fwd_b = i_dataB_EX;
        endcase
    end

    assign src_b = i_alu_src_EX ? i_imm_ext_EX : fwd_b;

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .src_a  (src_a),
        .src_b  (src_b),
        .op     (alu_op_e'(i_alu_control_EX)),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Not gated by stall; the hazard unit suppresses redirect when needed.
    assign o_pc_src_EX    = i_valid_EX & (i_jump_EX | (i_branch_EX & alu_zero));
    assign o_pc_target_EX = i_pc_EX + i_imm_ext_EX;

    // EX/MEM register: reset > flush > stall > capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_alu_result_MEM <= '0;
            o_write_data_MEM <= '0;
            o_pc_plus4_MEM   <= '0;
            o_addr_des_MEM   <= '0;
            o_reg_write_MEM  <= 1'b0;
            o_mem_write_MEM  <= 1'b0;
            o_result_src_MEM <= RES_ALU;
            o_valid_MEM      <= 1'b0;
        end else if (i_flush) begin
            o_alu_result_MEM <= '0;
            o_write_data_MEM <= '0;
            o_pc_plus4_MEM   <= '0;
            o_addr_des_MEM   <= '0;
            o_reg_write_MEM  <= 1'b0;
            o_mem_write_MEM  <= 1'b0;
            o_result_src_MEM <= RES_ALU;
            o_valid_MEM      <= 1'b0;
        end else if (!i_stall) begin
            o_alu_result_MEM <= alu_result;
            o_write_data_MEM <= fwd_b;
            o_pc_plus4_MEM   <= i_pc_plus4_EX;
            o_addr_des_MEM   <= i_addr_des_EX;
            // A bubble in EX must never produce architectural side effects.
            o_reg_write_MEM  <= i_reg_write_EX & i_valid_EX;
            o_mem_write_MEM  <= i_mem_write_EX & i_valid_EX;
            o_result_src_MEM <= i_result_src_EX;
            o_valid_MEM      <= i_valid_EX;
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register. It consumes that register's EX-side outputs.
- Each cycle it applies operand forwarding, computes the ALU result, resolves branch/jump (taken flag and target PC), and captures everything into the EX/MEM pipeline register that feeds the memory stage.
- The EX/MEM register supports stall (hold) and flush (bubble insertion) and carries a valid bit.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, destination register address width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid_EX  in  1  instruction in EX is real (not a bubble)
- i_dataA_EX  in  XLEN  rs1 value from ID/EX
- i_dataB_EX  in  XLEN  rs2 value from ID/EX
- i_pc_EX  in  XLEN  PC of instruction
- i_pc_plus4_EX  in  XLEN  PC+4
- i_imm_ext_EX  in  XLEN  sign-extended immediate
- i_addr_des_EX  in  REG_ADDR_W  rd
- i_alu_src_EX  in  1  0: B operand = forwarded rs2; 1: immediate
- i_branch_EX  in  1  conditional branch (BEQ)
- i_jump_EX  in  1  unconditional jump (JAL)
- i_mem_write_EX  in  1  store
- i_reg_write_EX  in  1  writes rd
- i_alu_control_EX  in  3  ALU opcode
- i_result_src_EX  in  2  WB result select, passed through
- i_forward_a_EX  in  2  operand A forward select
- i_forward_b_EX  in  2  operand B forward select
- i_alu_result_MEM  in  XLEN  forward source from MEM stage
- i_result_WB  in  XLEN  forward source from WB stage
- i_stall  in  1  hold EX/MEM register
- i_flush  in  1  load bubble into EX/MEM register
- o_pc_src_EX  out  1  redirect fetch (combinational)
- o_pc_target_EX  out  XLEN  i_pc_EX + i_imm_ext_EX (combinational)
- o_alu_result_MEM  out  XLEN  registered ALU result
- o_write_data_MEM  out  XLEN  registered forwarded rs2 (store data)
- o_pc_plus4_MEM  out  XLEN  registered PC+4
- o_addr_des_MEM  out  REG_ADDR_W  registered rd
- o_reg_write_MEM  out  1  registered
- o_mem_write_MEM  out  1  registered
- o_result_src_MEM  out  2  registered
- o_valid_MEM  out  1  registered valid

Behaviour:
- Forwarding select codes:
  - 00: register value
  - 01: i_result_WB
  - 10: i_alu_result_MEM
  - 11: reserved, behaves as 00
- SrcA = forwarded A. SrcB = i_alu_src_EX ? i_imm_ext_EX : forwarded B. The store data is always forwarded B.
- ALU opcodes (XLEN-bit, wrap-around, no overflow flag):
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed, result 0/1)
  - 110 SLL (shamt = SrcB[4:0])
  - 111 SRL (logical, shamt = SrcB[4:0])
- zero = (ALU result == 0).
- o_pc_src_EX = i_valid_EX & (i_jump_EX | (i_branch_EX & zero)). This is purely combinational, same cycle.
- o_pc_target_EX is always driven, independent of valid.
- Jump instructions: ALU result is don't-care. The WB stage selects pc_plus4 via result_src.
- EX/MEM register update on rising i_clk, priority order:
  1. i_rst asserted: all registered outputs 0, asynchronously, regardless of clock.
  2. i_flush: bubble. o_valid_MEM, o_reg_write_MEM and o_mem_write_MEM go to 0; o_result_src_MEM goes to 00; data fields go to 0.
  3. i_stall: all registered outputs hold.
  4. Otherwise: capture. o_valid_MEM <= i_valid_EX.
- When i_valid_EX = 0, captured reg_write and mem_write are forced to 0.
- Flush and stall asserted together: flush wins.
- Latency: one cycle from EX inputs to the *_MEM outputs.
- Reset mid-operation: all in-flight state is discarded. The first capture after i_rst deasserts occurs at the next rising edge.
- Stall does not gate o_pc_src_EX. Suppressing redirect during a stall is the hazard unit's responsibility.

Decomposition:
- Package pipeline_pkg holds:
  - alu_op_e (3-bit ALU codes above)
  - fwd_sel_e (FWD_REG, FWD_WB, FWD_MEM)
  - result_src codes (00 ALU, 01 memory, 10 PC+4)
  - XLEN default constant
- Sub-module alu: purely combinational, inputs SrcA, SrcB and op; outputs result and zero.
- The forwarding muxes and the EX/MEM register stay in ex_stage.

Test Plan:
- ADD with forwarding: A=5, B=7, alu_src=0, op=000, fwd 00/00, valid=1 -> next cycle o_alu_result_MEM=12, o_valid_MEM=1.
- Forwarding priority: fwd_a=10 with MEM=0x100, fwd_b=01 with WB=0x20, op=001 -> o_alu_result_MEM=0xE0 and o_write_data_MEM=0x20; repeat with fwd_a=11 -> register value is used.
- Branch taken vs. not taken: branch=1, A=B=0x55, pc=0x40, imm=0x10 -> o_pc_src_EX=1 and o_pc_target_EX=0x50 in the same cycle. With A≠B -> o_pc_src_EX=0. With valid=0 and A=B -> o_pc_src_EX=0.
- Shifts, SLT and wrap-around: SLT A=0xFFFFFFFF, B=1 -> 1. SRL A=0x80000000, B=0x21 -> 0x40000000. ADD 0xFFFFFFFF+1 -> 0.
- Stall and flush: capture an instruction with reg_write=1, then hold stall 2 cycles -> outputs unchanged. Assert stall and flush together -> o_valid_MEM=0, o_reg_write_MEM=0, o_mem_write_MEM=0.
- Asynchronous reset: assert i_rst between clock edges while o_valid_MEM=1 -> all *_MEM outputs 0 immediately. Deassert -> the next edge captures normally.
